// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The pipeline side is the master (raises requests); pipe_ctrl is the slave.
interface pipe_ctrl_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] exception_type;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output exception_type, cp0_epc,
        input  stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  exception_type, cp0_epc,
        output stall, flush, new_pc, stall_cycles, flush_count, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised per-stage stall vector, exception
// flush/redirect with a one-cycle refill bubble, and stall/flush statistics.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_ERET   = 32'h0000_000e,
    parameter int          WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_ID  = 6'b000111;

    state_t      state, state_nxt;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic [7:0]  run_len;
    logic        stall_active;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN, STALL: begin
                if (flush_c)
                    state_nxt = REFILL;
                else if (stall_c != 6'b0)
                    state_nxt = STALL;
                else
                    state_nxt = RUN;
            end
            REFILL:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs; reset forces them low so they read zero while rst is held.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can
        // leave a value held and infer a latch.
        stall_c  = 6'b0;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        if (!rst && state != REFILL) begin
            if (bus.exception_type != 32'h0) begin
                flush_c  = 1'b1;
                new_pc_c = (bus.exception_type == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
            end else if (bus.stallreq_from_mem) begin
                stall_c = STALL_MEM;
            end else if (bus.stallreq_from_ex) begin
                stall_c = STALL_EX;
            end else if (bus.stallreq_from_id) begin
                stall_c = STALL_ID;
            end
        end
    end

    assign stall_active = (stall_c != 6'b0);

    // Statistics and watchdog; flush already forces stall_c to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.stall_cycles  <= 32'h0;
            bus.flush_count   <= 16'h0;
            bus.stall_timeout <= 1'b0;
            run_len           <= 8'h0;
        end else begin
            if (stall_active && bus.stall_cycles != 32'hFFFF_FFFF)
                bus.stall_cycles <= bus.stall_cycles + 32'd1;
            if (flush_c && bus.flush_count != 16'hFFFF)
                bus.flush_count <= bus.flush_count + 16'd1;

            if (!stall_active || flush_c)
                run_len <= 8'h0;
            else if (run_len != 8'hFF)
                run_len <= run_len + 8'd1;

            // Flag rises on the edge where the run length reaches the limit.
            if (stall_active && !flush_c && (int'(run_len) + 1 >= WDOG_LIMIT))
                bus.stall_timeout <= 1'b1;
        end
    end

    assign bus.stall  = stall_c;
    assign bus.flush  = flush_c;
    assign bus.new_pc = new_pc_c;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock, clk, and an asynchronous active-high reset, rst; all state SHALL clear immediately on rst=1, independent of clk.
REQ-002 Port list (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 rst  in  1  async reset, active high
 stallreq_from_id  in  1  ID-stage load-use / operand hazard request
 stallreq_from_ex  in  1  EX-stage multicycle (mult/div) request
 stallreq_from_mem  in  1  MEM-stage data-RAM wait request
 exception_type  in  32  MEM-stage exception code; 0 = Exc_Default (none)
 cp0_epc  in  32  current CP0 EPC value
 stall  out  6  per-stage stop vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
 flush  out  1  pipeline flush to all stage registers
 new_pc  out  32  redirect target, valid while flush=1
 stall_cycles  out  32  count of cycles with stall!=0
 flush_count  out  16  count of flush pulses
 stall_timeout  out  1  sticky watchdog flag
REQ-003 Parameters (name, default, meaning): EXC_VECTOR, 32'h00000020, handler entry; EXC_ERET, 32'h0000000e, eret exception code; WDOG_LIMIT, 255, max continuous stall cycles.

Function
REQ-004 FSM states SHALL be RUN, STALL, REFILL.
REQ-005 stall, flush, new_pc SHALL be combinational from current state and inputs; counters, flag, state SHALL be registered.
REQ-006 In RUN/STALL, exception_type!=0 SHALL have top priority: flush=1, stall=6'b000000, next state REFILL.
REQ-007 new_pc SHALL equal cp0_epc when exception_type==EXC_ERET, EXC_VECTOR for any other nonzero code, 0 when flush=0.
REQ-008 With no exception, stall SHALL be: mem request 6'b011111; else ex 6'b001111; else id 6'b000111; else 6'b000000 (priority mem>ex>id).
REQ-009 Transitions: RUN->STALL when stall!=0; STALL->RUN when stall==0; STALL/RUN->REFILL on exception; REFILL->RUN unconditionally after exactly one cycle.
REQ-010 In REFILL, stall SHALL be 0, flush SHALL be 0, and all stall requests and exception_type SHALL be ignored (flushed NOPs occupy the pipeline).
REQ-011 stall_cycles SHALL increment by 1 on each clock edge where stall!=0, saturating at 32'hFFFFFFFF.
REQ-012 flush_count SHALL increment by 1 on each clock edge where flush=1, saturating at 16'hFFFF.
REQ-013 An internal 8-bit run-length counter SHALL increment while stall!=0 and clear to 0 when stall==0 or flush=1; on reaching WDOG_LIMIT, stall_timeout SHALL set and stay 1 until rst.
REQ-014 Watchdog SHALL NOT force stall release; it is observation only.
REQ-015 Simultaneous exception and any stall request: exception wins, stall=0, run-length counter clears, stall_cycles does not increment that cycle.
REQ-016 A stall request held continuously SHALL keep stall constant each cycle with no gap cycles.

Reset
REQ-017 On rst=1: state=RUN, stall=0, flush=0, new_pc=0, stall_cycles=0, flush_count=0, stall_timeout=0, run-length counter=0, regardless of inputs.
REQ-018 Reset asserted mid-STALL or mid-REFILL SHALL abort the state; first cycle after release SHALL be RUN.

Verification
REQ-019 stallreq_from_ex=1 for 32 cycles, then 0 -> stall=6'b001111 for 32 cycles, state returns RUN, stall_cycles=32.
REQ-020 stallreq_from_id=1 and stallreq_from_mem=1 together -> stall=6'b011111; drop mem -> stall=6'b000111 next evaluation.
REQ-021 exception_type=32'h0000000e, cp0_epc=32'h00001234, stallreq_from_ex=1 -> flush=1, new_pc=32'h00001234, stall=0; next cycle REFILL with stall=0 despite request; then stall=6'b001111; flush_count=1.
REQ-022 exception_type=32'h00000008 -> new_pc=32'h00000020; same code held in REFILL cycle -> no second flush.
REQ-023 stallreq_from_mem held 300 cycles -> stall_timeout=1 after cycle 255, stays 1 after release; rst -> 0.
REQ-024 rst pulsed asynchronously (between edges) during STALL -> all outputs 0 immediately; after release with no requests, stall=0, counters 0.
